// File: rtl/newsstand_vend_pkg.sv
// ============================================================================
// Module   : newsstand_pkg
// Brief    : Shared types, coin denominations and coin valuation for the vendor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package newsstand_pkg;

    typedef enum logic [1:0] {
        NOCOIN  = 2'b00,
        NICKEL  = 2'b01,
        DIME    = 2'b10,
        QUARTER = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;

    function automatic logic [4:0] coin_value(input coin_t c);
        case (c)
            NICKEL:  coin_value = 5'(NICKEL_C);
            DIME:    coin_value = 5'(DIME_C);
            QUARTER: coin_value = 5'(QUARTER_C);
            default: coin_value = 5'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/newsstand_vend_if.sv
// ============================================================================
// Module   : newsstand_vend_if
// Brief    : Coin-acceptor / actuator bundle between front end and vendor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface newsstand_vend_if #(
    parameter int CREDIT_W = 6
) ();
    import newsstand_pkg::*;

    coin_t               coin;
    logic                cancel;
    logic                restock;
    logic                newspaper;
    logic                change_nickel;
    logic                coin_reject;
    logic                busy;
    logic                sold_out;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin, cancel, restock,
        input  newspaper, change_nickel, coin_reject, busy, sold_out, credit
    );

    modport slave (
        input  coin, cancel, restock,
        output newspaper, change_nickel, coin_reject, busy, sold_out, credit
    );

endinterface

`default_nettype wire

// File: rtl/newsstand_vend_stock.sv
// ============================================================================
// Module   : newsstand_stock
// Brief    : Inventory counter with restock load, vend decrement and zero flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module newsstand_stock #(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic load_i,
    input  wire logic dec_i,
    output logic      zero_o
);

    generate
        if (STOCK_INIT < 0 || STOCK_INIT >= (1 << STOCK_W)) begin : g_bad_stock_init
            $fatal(1, "STOCK_INIT does not fit in STOCK_W bits");
        end
    endgenerate

    localparam logic [STOCK_W-1:0] c_init = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] stock_q;
    logic [STOCK_W-1:0] stock_d;

    // Load has priority so a restock landing on a vend edge leaves a full rack.
    always_comb begin
        stock_d = stock_q;
        if (load_i) begin
            stock_d = c_init;
        end else if (dec_i && (stock_q != '0)) begin
            stock_d = stock_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stock_q <= c_init;
        end else begin
            stock_q <= stock_d;
        end
    end

    assign zero_o = (stock_q == '0);

endmodule

`default_nettype wire

// File: rtl/newsstand_vend.sv
// ============================================================================
// Module   : newsstand_vend
// Brief    : Coin-accumulating newspaper vendor with refund and nickel change.
// Revision : 1.0
// ============================================================================
`default_nettype none

module newsstand_vend
    import newsstand_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int CREDIT_W   = 6,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    newsstand_vend_if.slave  bus
);

    generate
        if ((PRICE < 5) || ((PRICE % 5) != 0)) begin : g_bad_price
            $fatal(1, "PRICE must be a positive multiple of 5");
        end
        if ((PRICE - 5 + 25) >= (1 << CREDIT_W)) begin : g_bad_credit_w
            $fatal(1, "CREDIT_W too narrow to hold PRICE-5+25");
        end
    endgenerate

    localparam int                  SUM_W    = CREDIT_W + 1;
    localparam logic [SUM_W-1:0]    c_price  = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] c_nickel = CREDIT_W'(NICKEL_C);

    state_t              state_q;
    state_t              state_d;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic                coin_reject_q;
    logic                coin_reject_d;
    logic                newspaper_q;
    logic                change_q;
    logic                busy_q;

    logic                w_sold_out;
    logic                w_vend;
    logic                w_has_coin;
    logic                w_take;
    logic [SUM_W-1:0]    w_sum;

    assign w_has_coin = (bus.coin != NOCOIN);
    assign w_take     = w_has_coin && !bus.cancel && !w_sold_out &&
                        ((state_q == IDLE) || (state_q == COLLECT));
    assign w_sum      = {1'b0, credit_q} + SUM_W'(coin_value(bus.coin));
    assign w_vend     = (state_q == VEND);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = w_has_coin && !w_take;

        case (state_q)
            IDLE, COLLECT: begin
                if ((state_q == COLLECT) && bus.cancel) begin
                    state_d = CHANGE;
                end else if (w_take) begin
                    if (w_sum < c_price) begin
                        credit_d = w_sum[CREDIT_W-1:0];
                        state_d  = COLLECT;
                    end else begin
                        credit_d = CREDIT_W'(w_sum - c_price);
                        state_d  = VEND;
                    end
                end
            end
            VEND: begin
                state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                // Last nickel leaves on the cycle credit reads 5; never underflow.
                if (credit_q <= c_nickel) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - c_nickel;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
            newspaper_q   <= 1'b0;
            change_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
            newspaper_q   <= (state_d == VEND);
            change_q      <= (state_d == CHANGE);
            busy_q        <= (state_d == VEND) || (state_d == CHANGE);
        end
    end

    newsstand_stock #(
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (bus.restock),
        .dec_i   (w_vend),
        .zero_o  (w_sold_out)
    );

    assign bus.newspaper     = newspaper_q;
    assign bus.change_nickel = change_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.busy          = busy_q;
    assign bus.sold_out      = w_sold_out;
    assign bus.credit        = credit_q;

endmodule

`default_nettype wire
